serial_add_sequencer: RTL and testbench

//  Bit-serial add/subtract controller for the scalar ALU. It sequences one shared full_adder

---
 rtl/serial_add_sequencer.sv | 177 +++++++++++++++++
 tb/tb_serial_add_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract sequencer: one shared full-adder cell stepped LSB first
// over WIDTH cycles, with valid/ready handshakes on the request and result sides.

// Single-bit full adder cell shared by the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum_c,
    output logic cout_c
);
    assign sum_c  = a ^ b ^ c_in;
    assign cout_c = (a & b) | (c_in & (a ^ b));
endmodule

module serial_add_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   r_sh_q, r_sh_d;
    logic               cy_q, cy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               start_ready_q, start_ready_d;
    logic               res_valid_q, res_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_out_q, carry_out_d;
    logic               overflow_q, overflow_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;

    logic               fa_sum_c;
    logic               fa_cout_c;

    // The only arithmetic element on the datapath.
    full_adder u_fa (
        .a      (a_sh_q[0]),
        .b      (b_sh_q[0]),
        .c_in   (cy_q),
        .sum_c  (fa_sum_c),
        .cout_c (fa_cout_c)
    );

    // State, shift registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            a_sh_q        <= '0;
            b_sh_q        <= '0;
            r_sh_q        <= '0;
            cy_q          <= 1'b0;
            cnt_q         <= '0;
            start_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
            result_q      <= '0;
            carry_out_q   <= 1'b0;
            overflow_q    <= 1'b0;
            zero_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_sh_q        <= a_sh_d;
            b_sh_q        <= b_sh_d;
            r_sh_q        <= r_sh_d;
            cy_q          <= cy_d;
            cnt_q         <= cnt_d;
            start_ready_q <= start_ready_d;
            res_valid_q   <= res_valid_d;
            result_q      <= result_d;
            carry_out_q   <= carry_out_d;
            overflow_q    <= overflow_d;
            zero_q        <= zero_d;
            busy_q        <= busy_d;
        end
    end

    // Next-state and datapath sequencing; outputs are computed one cycle ahead so they are registered.
    always_comb begin
        state_d       = state_q;
        a_sh_d        = a_sh_q;
        b_sh_d        = b_sh_q;
        r_sh_d        = r_sh_q;
        cy_d          = cy_q;
        cnt_d         = cnt_q;
        start_ready_d = start_ready_q;
        res_valid_d   = res_valid_q;
        result_d      = result_q;
        carry_out_d   = carry_out_q;
        overflow_d    = overflow_q;
        zero_d        = zero_q;
        busy_d        = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_valid && start_ready_q) begin
                    // Subtraction is A + ~B + 1: invert B and seed the carry with sub.
                    a_sh_d        = op_a;
                    b_sh_d        = op_b ^ {WIDTH{sub}};
                    cy_d          = sub;
                    cnt_d         = '0;
                    state_d       = ST_RUN;
                    start_ready_d = 1'b0;
                    busy_d        = 1'b1;
                end
            end

            ST_RUN: begin
                r_sh_d = {fa_sum_c, r_sh_q[WIDTH-1:1]};
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                cy_d   = fa_cout_c;
                if (cnt_q == CNT_LAST) begin
                    // cy_q here is the carry into the MSB; overflow is it XOR the carry out.
                    state_d     = ST_DONE;
                    res_valid_d = 1'b1;
                    result_d    = r_sh_d;
                    carry_out_d = fa_cout_c;
                    overflow_d  = cy_q ^ fa_cout_c;
                    zero_d      = ~|r_sh_d;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                if (res_ready) begin
                    state_d       = ST_IDLE;
                    res_valid_d   = 1'b0;
                    start_ready_d = 1'b1;
                    busy_d        = 1'b0;
                end
            end

            default: begin
                state_d       = ST_IDLE;
                res_valid_d   = 1'b0;
                start_ready_d = 1'b1;
                busy_d        = 1'b0;
            end
        endcase
    end

    assign start_ready = start_ready_q;
    assign res_valid   = res_valid_q;
    assign result      = result_q;
    assign carry_out   = carry_out_q;
    assign overflow    = overflow_q;
    assign zero        = zero_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer at WIDTH=8 with an expected-result queue.
module tb_serial_add_sequencer;
    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;
    logic         busy;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    serial_add_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .sub         (sub),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .carry_out   (carry_out),
        .overflow    (overflow),
        .zero        (zero),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain wide addition, signed overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t        e;
        logic [W:0]  full;
        logic [W-1:0] bb;
        bb     = s ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + (W+1)'(s);
        e.r    = full[W-1:0];
        e.c    = full[W];
        e.v    = s ? ((a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]))
                   : ((a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]));
        e.z    = (e.r == '0);
        return e;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_rv"},    32'(res_valid), 32'd0);
        chk({tag, "_sr"},    32'(start_ready), 32'd1);
    endtask

    // Issue one request, wait for the result, compare against the queue, then accept it.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input bit scramble, input bit backpressure, input string tag);
        int   lat;
        exp_t e;
        logic [W-1:0] r0;
        logic c0, v0, z0;
        op_a = a; op_b = b; sub = s; start_valid = 1'b1;
        sb.push_back(model(a, b, s));
        step();
        start_valid = 1'b0;
        chk({tag, "_busy_run"}, 32'(busy), 32'd1);
        chk({tag, "_sr_run"},   32'(start_ready), 32'd0);
        lat = 0;
        while (!res_valid && lat < 20) begin
            if (scramble) begin
                op_a = W'($urandom);
                op_b = W'($urandom);
                sub  = ~sub;
            end
            start_valid = scramble;
            step();
            lat++;
        end
        start_valid = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(W));
        e = sb.pop_front();
        chk({tag, "_result"}, 32'(result), 32'(e.r));
        chk({tag, "_carry"},  32'(carry_out), 32'(e.c));
        chk({tag, "_ovf"},    32'(overflow), 32'(e.v));
        chk({tag, "_zero"},   32'(zero), 32'(e.z));
        if (backpressure) begin
            r0 = result; c0 = carry_out; v0 = overflow; z0 = zero;
            for (int i = 0; i < 5; i++) begin
                start_valid = (i == 2);
                op_a = W'($urandom); op_b = W'($urandom);
                step();
                chk({tag, "_bp_rv"},  32'(res_valid), 32'd1);
                chk({tag, "_bp_sr"},  32'(start_ready), 32'd0);
                chk({tag, "_bp_res"}, 32'({result, carry_out, overflow, zero}),
                    32'({r0, c0, v0, z0}));
            end
            start_valid = 1'b0;
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check_idle({tag, "_post"});
        chk({tag, "_hold"}, 32'(result), 32'(e.r));
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
        op_a = '0; op_b = '0; sub = 1'b0;
        repeat (3) step();
        check_idle("rst");
        chk("rst_result", 32'({result, carry_out, overflow, zero}), 32'd0);
        rst_n = 1'b1;
        step();
        check_idle("rel");

        // Reset in the middle of RUN at cnt=3.
        op_a = 8'h12; op_b = 8'h34; sub = 1'b0; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check_idle("midrst");
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 2 * W; i++) begin
            step();
            if (res_valid || busy) seen++;
        end
        chk("midrst_no_result", 32'(seen), 32'd0);

        run_op(8'h3C, 8'h0F, 1'b0, 1'b0, 1'b0, "add_3c_0f");
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, "add_ff_01");
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, "add_7f_01");
        run_op(8'h05, 8'h07, 1'b1, 1'b0, 1'b0, "sub_05_07");
        run_op(8'h80, 8'h01, 1'b1, 1'b0, 1'b1, "sub_80_01_bp");
        step();
        check_idle("bp_not_taken");
        run_op(8'hA5, 8'h5A, 1'b0, 1'b1, 1'b0, "iso_add");
        run_op(8'h13, 8'hC4, 1'b1, 1'b1, 1'b0, "iso_sub");
        for (int k = 0; k < 6; k++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0, "rand");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
